// File: rtl/memory_game_pkg.sv
// Shared constants, FSM encoding and load-beat struct for the memory game.
package memory_game_pkg;

  localparam int          CARD_CNT   = 16;
  localparam int          CARD_IDX_W = 4;
  localparam int          COLOR_W    = 12;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PICK = 3'd2,
    ST_SWAP = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [CARD_IDX_W-1:0] addr;
    logic [COLOR_W-1:0]    color;
  } load_req_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (right-shifting, taps LFSR_TAPS); never zero from a non-zero seed.
module lfsr16
  import memory_game_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/card_shuffler.sv
// Card-layout store with in-place Fisher-Yates shuffle and registered read port.
// CARD_SHUFFLE_EN enables the PICK/SWAP shuffle; without it the layout stays as loaded.
module card_shuffler
  import memory_game_pkg::*;
#(
  parameter int          CARD_CNT = 16,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  load_valid,
  input  logic [CARD_IDX_W-1:0] load_addr,
  input  logic [COLOR_W-1:0]    load_color,
  input  logic                  load_last,
  input  logic [CARD_IDX_W-1:0] rd_addr,
  output logic [COLOR_W-1:0]    rd_color,
  output logic                  busy,
  output logic                  done
);

  state_e             state_q, state_d;
  logic [COLOR_W-1:0] mem_q [CARD_CNT];
  logic [COLOR_W-1:0] mem_d [CARD_CNT];
  logic [COLOR_W-1:0] rd_color_q, rd_color_d;
  logic [15:0]        lfsr;
  load_req_t          ld;

  assign ld = '{valid: load_valid, last: load_last, addr: load_addr, color: load_color};

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

`ifdef CARD_SHUFFLE_EN
  logic [CARD_IDX_W-1:0] i_q, i_d, j_q, j_d, cand;
  assign cand = lfsr[CARD_IDX_W-1:0];
`else
  logic lfsr_unused;
  assign lfsr_unused = ^lfsr;
`endif

  // Next state; start restarts the round from any state
  always_comb begin
    state_d = state_q;
`ifdef CARD_SHUFFLE_EN
    i_d = i_q;
    j_d = j_q;
`endif
    if (start) begin
      state_d = ST_LOAD;
`ifdef CARD_SHUFFLE_EN
      i_d = '0;
`endif
    end else begin
      unique case (state_q)
        ST_LOAD: if (ld.valid && ld.last) begin
`ifdef CARD_SHUFFLE_EN
          state_d = ST_PICK;
          i_d     = CARD_IDX_W'(CARD_CNT - 1);
`else
          state_d = ST_DONE;
`endif
        end
`ifdef CARD_SHUFFLE_EN
        // Reject candidates above i so every j in 0..i is equally likely
        ST_PICK: if (cand <= i_q) begin
          j_d     = cand;
          state_d = ST_SWAP;
        end
        ST_SWAP: begin
          if (i_q == CARD_IDX_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            i_d     = i_q - CARD_IDX_W'(1);
            state_d = ST_PICK;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Memory update; a concurrent start drops the write or swap
  always_comb begin
    mem_d = mem_q;
    if (!start) begin
      if (state_q == ST_LOAD && ld.valid) mem_d[ld.addr] = ld.color;
`ifdef CARD_SHUFFLE_EN
      if (state_q == ST_SWAP) begin
        mem_d[i_q] = mem_q[j_q];
        mem_d[j_q] = mem_q[i_q];
      end
`endif
    end
  end

  always_comb begin
    busy       = (state_q == ST_LOAD) || (state_q == ST_PICK) || (state_q == ST_SWAP);
    done       = (state_q == ST_DONE);
    rd_color_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_color_q <= '0;
      for (int k = 0; k < CARD_CNT; k++) mem_q[k] <= '0;
`ifdef CARD_SHUFFLE_EN
      i_q <= '0;
      j_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_color_q <= rd_color_d;
      mem_q      <= mem_d;
`ifdef CARD_SHUFFLE_EN
      i_q <= i_d;
      j_q <= j_d;
`endif
    end
  end

  assign rd_color = rd_color_q;

endmodule

// File: doc/card_shuffler.md
# card_shuffler

Card-layout store and shuffler for the memory game. Captures the 16 card colours produced by the colour generator, one write per beat. Then permutes them in place with a Fisher-Yates shuffle driven by a free-running LFSR. After that it serves the shuffled layout to the board renderer through a registered read port.

## Interface
Parameters:
- CARD_CNT, 16: number of cards; fixed power of two, index width 4.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high; clock clk.
- start  in  1  one-cycle pulse; begins a new load/shuffle round.
- load_valid  in  1  write strobe for one card.
- load_addr  in  4  card index written.
- load_color  in  12  RGB444 colour written.
- load_last  in  1  qualifies the final load beat; ends the load phase.
- rd_addr  in  4  renderer read index.
- rd_color  out  12  colour at rd_addr, registered.
- busy  out  1  high in LOAD, PICK and SWAP.
- done  out  1  high in DONE; held until the next start or rst.

## Operation
- Storage: 16 x 12-bit register file mem[].
- LFSR: 16-bit Galois, taps 16'hB400. Advances every cycle in every state, including IDLE, so player timing seeds the shuffle. It never holds zero.
- FSM states: IDLE, LOAD, PICK, SWAP, DONE.
- IDLE or DONE, start=1: go to LOAD.
- start=1 in LOAD, PICK or SWAP: restart into LOAD. The index counter is reset; mem is not cleared.
- LOAD, load_valid=1: mem[load_addr] <= load_color.
  - load_valid=0: nothing is written.
  - load_valid with load_last: performs the write, sets i <= 15, goes to PICK.
  - load_last without load_valid is ignored.
- PICK: candidate j = lfsr[3:0].
  - If j <= i: latch j and go to SWAP.
  - Otherwise stay in PICK (rejection sampling keeps the distribution uniform).
- SWAP: mem[i] <= mem[j] and mem[j] <= mem[i] in the same cycle. j == i leaves the entry unchanged.
  - If i == 1: go to DONE.
  - Otherwise i <= i-1 and go to PICK.
- DONE: mem is frozen; load_valid is ignored.
- load_valid is ignored outside LOAD.
- Read port: rd_color <= mem[rd_addr] every cycle, in every state. During PICK/SWAP it returns intermediate contents.

## Timing
- Reset values:
  - state IDLE, busy 0, done 0, rd_color 12'h000.
  - every mem entry 12'h000, lfsr = SEED, i = 0, j = 0.
- start sampled at edge N: busy=1 from N+1.
- A load write sampled at edge N is visible on rd_color two edges later when rd_addr points to it.
- Shuffle:
  - 15 iterations, each at least 2 cycles (PICK + SWAP).
  - Minimum 30 cycles from the first PICK to DONE.
  - No upper bound, but each PICK cycle accepts with probability at least 2/16.
- done rises and busy falls on the edge after the final SWAP (i == 1).
- start in the same cycle as a load write: start wins and the write is dropped.
- rst during any state returns the block to its reset values on the next edge.

## Configuration
- CARD_SHUFFLE_EN defined: full behaviour as above.
- CARD_SHUFFLE_EN undefined:
  - PICK and SWAP are not compiled. The load_last beat goes straight to DONE, and mem holds the layout exactly as loaded.
  - The LFSR is still present.
  - This gives a deterministic board for debug and for the renderer bench.

## Structure
- Shared memory_game_pkg holds:
  - constants CARD_CNT=16, CARD_IDX_W=4, COLOR_W=12, LFSR_SEED, LFSR_TAPS;
  - the FSM state typedef/encodings.
- One sub-module, lfsr16: enable-free, synchronous reset to SEED, outputs the 16-bit state.

## Test plan
- Reset: assert rst 2 cycles -> rd_color=000 for all rd_addr 0..15, busy=0, done=0.
- Macro off, load addr k with colour table (0,1 F00; 2,3 FF0; 4,5 FFF; 6,7 00F; 8,9 0FF; 10,11 F0F; 12..15 000), last on addr 15 -> done on the next edge; readback matches exactly.
- Macro on, same load -> done within 30..1000 cycles, busy=0. The readback multiset equals the loaded multiset: two each of F00, FF0, FFF, 00F, 0FF, F0F and four of 000.
- Macro on, force an LFSR state whose [3:0] exceeds i -> PICK persists, no mem change that cycle; the swap occurs only once j <= i.
- start pulsed mid-shuffle -> busy stays 1, state LOAD, done=0. A fresh 16-beat load then re-shuffles to DONE.
- load_valid without load_last, and load_last without load_valid -> state remains LOAD; only the valid beat writes.
